echo_shift_fifo: RTL and testbench
==================================

// Module: echo_shift_fifo
// PURPOSE
//  Command-driven capture/return block with a DEPTH-entry FIFO and a selectable shift unit.
//  A capture command pushes data_in into the FIFO.
//  A return command pops the oldest word, shifts or rotates it as encoded in the command, and drives
//  the result onto the shared tri-state data bus. Sits as a peripheral next to the Nios II bus bridge.
// PARAMETERS
//  DATA_W  16  data word width (>=2)
//  DEPTH    8  FIFO entries (>=2, any value; pointers wrap DEPTH-1 -> 0)
//  CMD_W    8  command width; must be >= 4+SHW, SHW=$clog2(DATA_W)
// PORTS
//  clk          in   1       single clock, all logic rising-edge
//  reset        in   1       synchronous, active-high
//  cmd_valid    in   1       command strobe
//  cmd_ready    out  1       command accepted when cmd_valid&&cmd_ready at clk edge
//  cmd          in   CMD_W   [0] op 0=capture 1=return; [2:1] mode; [3+:SHW] amount; [CMD_W-1] flush
//  data_in      in   DATA_W  word captured on accepted capture
//  data_out     out  DATA_W  tri-state: result when data_out_en=1, else all 'z
//  data_out_en  out  1       bus drive enable (registered)
//  out_valid    out  1       one-cycle pulse: new result on data_out
//  fifo_count   out  $clog2(DEPTH+1)  occupied entries
//  err_reject   out  1       sticky: cmd_valid seen with cmd_ready=0
// BEHAVIOUR
//  Reset: FIFO empty, pointers 0, fifo_count=0, pipeline empty, data_out_en=0, out_valid=0,
//    result reg=0, err_reject=0. Reset mid-operation drops in-flight returns.
//  Decode priority: flush, then op.
//  cmd_ready (combinational on cmd): flush -> 1; capture -> !full; return -> !empty.
//  Capture accepted: write data_in at wr_ptr, wr_ptr++, count++. Also clears data_out_en
//    (bus released) unless a stage-2 completion occurs the same cycle; the completion wins.
//  Return accepted (edge N): pop head into stage-1 reg with mode/amount, rd_ptr++, count--.
//    Edge N+1: stage 2 writes the shifted result, sets data_out_en=1, out_valid=1 for one cycle.
//    Latency = 2 clocks acceptance->out_valid. Back-to-back returns are fully pipelined.
//  Mode: 00 SHL logical, 01 SHR logical, 10 SHR arithmetic (sign = MSB), 11 rotate left.
//    Amount 0 = pass-through. Amounts >= DATA_W are impossible by SHW width. Result width DATA_W;
//    shifted-out bits are discarded.
//  Flush accepted: FIFO emptied (pointers 0, count 0), stage-1 entry killed, data_out_en=0, err_reject=0.
//    A stage-2 completion in the flush cycle is suppressed (flush wins).
//  Full: capture rejected, no state change, err_reject<=1. Empty: return likewise.
//  data_out holds the last result while data_out_en=1. No push and pop can coincide (single cmd port).
//  data_out_en and the result are registers; only the final 'z mux is combinational.
// STRUCTURE
//  Shared package echo_pkg: localparams OP_CAPTURE/OP_RETURN, MODE_SHL/SHR/SRA/ROL,
//    field positions CMD_OP_BIT, CMD_MODE_LSB, CMD_AMT_LSB.
//  Sub-module: echo_shift_unit (combinational DATA_W shifter: in, mode, amount -> out),
//    instantiated in stage 2.
//  Top: FIFO storage and pointers, 2-stage return pipeline, tri-state output mux.
// TESTING
//  1 DATA_W=16: capture 16'h1234; return cmd=8'h19 (SHL by 3). Expect out_valid 2 clk later,
//    data_out=16'h91A0, data_out_en=1.
//  2 Fill 8 captures: count=8, cmd_ready=0 for a 9th capture. Expect err_reject=1, count stays 8.
//    Drain 8 returns with amount 0: data in FIFO order, pointers wrap correctly.
//  3 Modes on 16'h8001, amount 1: SHL->16'h0002, SHR->16'h4000, SRA->16'hC000, ROL->16'h0003.
//  4 Return on empty FIFO -> cmd_ready=0, no out_valid, err_reject=1. Then flush -> err_reject=0,
//    data_out_en=0, bus reads 'z.
//  5 Back-to-back returns on 3 words -> out_valid on 3 consecutive cycles. Flush one cycle after
//    the 2nd return -> only the 1st result appears, count=0.
//  6 Assert reset with a return in stage 1 -> no out_valid afterwards, all outputs at reset values.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared definitions for the echo_shift_fifo peripheral.
// Contents: command opcodes, shift-mode encodings and command field positions.
package echo_pkg;

   // cmd[CMD_OP_BIT]
   localparam logic OP_CAPTURE = 1'b0;
   localparam logic OP_RETURN  = 1'b1;

   // cmd[CMD_MODE_LSB +: 2]
   localparam logic [1:0] MODE_SHL = 2'b00;  // shift left logical
   localparam logic [1:0] MODE_SHR = 2'b01;  // shift right logical
   localparam logic [1:0] MODE_SRA = 2'b10;  // shift right arithmetic
   localparam logic [1:0] MODE_ROL = 2'b11;  // rotate left

   // Command field positions; the flush bit is always the command MSB.
   localparam int unsigned CMD_OP_BIT   = 0;
   localparam int unsigned CMD_MODE_LSB = 1;
   localparam int unsigned CMD_AMT_LSB  = 3;

endpackage

// File: rtl/echo_shift_unit.sv
// Combinational DATA_W-bit shifter / rotator.
// Ports:
//   din     in   DATA_W  word to shift
//   mode    in   2       MODE_SHL / MODE_SHR / MODE_SRA / MODE_ROL
//   amount  in   SHW     shift distance, 0 = pass-through
//   dout    out  DATA_W  result; shifted-out bits are discarded
module echo_shift_unit
   import echo_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned SHW    = $clog2(DATA_W)
) (
   input  logic [DATA_W-1:0] din,
   input  logic [1:0]        mode,
   input  logic [SHW-1:0]    amount,
   output logic [DATA_W-1:0] dout
);

   // Rotate: shift a doubled copy left, the upper half is the rotated word.
   logic [2*DATA_W-1:0] dbl;

   always_comb begin
      dbl  = {din, din} << amount;
      dout = din;
      case (mode)
         MODE_SHL: dout = din << amount;
         MODE_SHR: dout = din >> amount;
         MODE_SRA: dout = $signed(din) >>> amount;
         MODE_ROL: dout = dbl[2*DATA_W-1:DATA_W];
         default:  dout = din;
      endcase
   end

endmodule

// File: rtl/echo_shift_fifo.sv
// Command-driven capture/return peripheral: DEPTH-entry FIFO, 2-stage return
// pipeline with a selectable shift unit, tri-state result bus.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   cmd_valid     command strobe
//   cmd_ready     command would be accepted (combinational on cmd)
//   cmd           [0] op, [2:1] mode, [3+:SHW] amount, [CMD_W-1] flush
//   data_in       word stored by an accepted capture
//   data_out      result while data_out_en=1, else 'z
//   data_out_en   registered bus drive enable
//   out_valid     one-cycle pulse when a new result is driven
//   fifo_count    occupied entries
//   err_reject    sticky flag: cmd_valid seen while cmd_ready=0
module echo_shift_fifo
   import echo_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned CMD_W  = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [CMD_W-1:0]           cmd,
   input  logic [DATA_W-1:0]          data_in,
   output logic [DATA_W-1:0]          data_out,
   output logic                       data_out_en,
   output logic                       out_valid,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
   output logic                       err_reject
);

   localparam int unsigned SHW = $clog2(DATA_W);
   localparam int unsigned PW  = $clog2(DEPTH);
   localparam int unsigned CW  = $clog2(DEPTH+1);

   localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

   // Command decode
   logic           c_flush;
   logic           c_op;
   logic [1:0]     c_mode;
   logic [SHW-1:0] c_amt;
   logic           fifo_full;
   logic           fifo_empty;
   logic           accept;
   logic           do_flush;
   logic           do_cap;
   logic           do_ret;
   logic           complete;

   // State
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] s1_data_q, s1_data_d;
   logic [1:0]        s1_mode_q, s1_mode_d;
   logic [SHW-1:0]    s1_amt_q, s1_amt_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              out_en_q, out_en_d;
   logic              out_valid_q, out_valid_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] shift_out;

   always_comb begin
      c_flush    = cmd[CMD_W-1];
      c_op       = cmd[CMD_OP_BIT];
      c_mode     = cmd[CMD_MODE_LSB +: 2];
      c_amt      = cmd[CMD_AMT_LSB +: SHW];
      fifo_full  = (count_q == COUNT_FULL);
      fifo_empty = (count_q == '0);

      if (c_flush)                cmd_ready = 1'b1;
      else if (c_op == OP_RETURN) cmd_ready = !fifo_empty;
      else                        cmd_ready = !fifo_full;

      accept   = cmd_valid && cmd_ready;
      do_flush = accept && c_flush;
      do_cap   = accept && !c_flush && (c_op == OP_CAPTURE);
      do_ret   = accept && !c_flush && (c_op == OP_RETURN);
      // A flush in the same cycle suppresses the stage-2 completion.
      complete = s1_valid_q && !do_flush;
   end

   echo_shift_unit #(
      .DATA_W (DATA_W),
      .SHW    (SHW)
   ) u_shift (
      .din    (s1_data_q),
      .mode   (s1_mode_q),
      .amount (s1_amt_q),
      .dout   (shift_out)
   );

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      s1_valid_d  = do_ret;
      s1_data_d   = s1_data_q;
      s1_mode_d   = s1_mode_q;
      s1_amt_d    = s1_amt_q;
      result_d    = result_q;
      out_en_d    = out_en_q;
      out_valid_d = complete;
      err_d       = err_q;

      if (do_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else if (do_cap) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
         count_d  = count_q + 1'b1;
      end else if (do_ret) begin
         rd_ptr_d  = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
         count_d   = count_q - 1'b1;
         s1_data_d = mem_q[rd_ptr_q];
         s1_mode_d = c_mode;
         s1_amt_d  = c_amt;
      end

      if (complete) result_d = shift_out;

      // Priority: flush releases the bus, a completion drives it, a capture releases it.
      if (do_flush)      out_en_d = 1'b0;
      else if (complete) out_en_d = 1'b1;
      else if (do_cap)   out_en_d = 1'b0;

      if (do_flush)                     err_d = 1'b0;
      else if (cmd_valid && !cmd_ready) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_mode_q   <= '0;
         s1_amt_q    <= '0;
         result_q    <= '0;
         out_en_q    <= 1'b0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
         s1_mode_q   <= s1_mode_d;
         s1_amt_q    <= s1_amt_d;
         result_q    <= result_d;
         out_en_q    <= out_en_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (!reset && do_cap) mem_q[wr_ptr_q] <= data_in;
   end

   assign data_out    = out_en_q ? result_q : 'z;
   assign data_out_en = out_en_q;
   assign out_valid   = out_valid_q;
   assign fifo_count  = count_q;
   assign err_reject  = err_q;

endmodule

// File: tb/tb_echo_shift_fifo.sv
// Directed, table-driven bench for echo_shift_fifo (DATA_W=16, DEPTH=8, CMD_W=8).
module tb_echo_shift_fifo;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        data_out_en;
   logic        out_valid;
   logic [3:0]  fifo_count;
   logic        err_reject;

   int n_cmp  = 0;
   int n_fail = 0;

   localparam logic [7:0] CMD_CAP   = 8'h00;
   localparam logic [7:0] CMD_FLUSH = 8'h80;

   echo_shift_fifo #(
      .DATA_W (16),
      .DEPTH  (8),
      .CMD_W  (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd         (cmd),
      .data_in     (data_in),
      .data_out    (data_out),
      .data_out_en (data_out_en),
      .out_valid   (out_valid),
      .fifo_count  (fifo_count),
      .err_reject  (err_reject)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] din;
      logic [1:0]  mode;
      logic [3:0]  amt;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[11];

   function automatic logic [7:0] mk_ret(input logic [1:0] mode, input logic [3:0] amt);
      return {1'b0, amt, mode, 1'b1};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bus is released: 'z in a 4-state simulator, resolves to 0 in a 2-state one.
   task automatic check_released(input string name);
      check({name, "_en"}, 32'(data_out_en), 32'd0);
      check({name, "_bus"}, 32'($isunknown(data_out) || (data_out == 16'h0)), 32'd1);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_capture(input logic [15:0] d);
      cmd       = CMD_CAP;
      data_in   = d;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic do_flush();
      cmd       = CMD_FLUSH;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   logic [15:0] fill [8];

   initial begin
      vecs[0]  = '{16'h1234, 2'b00, 4'd3,  16'h91A0};
      vecs[1]  = '{16'h8001, 2'b00, 4'd1,  16'h0002};
      vecs[2]  = '{16'h8001, 2'b01, 4'd1,  16'h4000};
      vecs[3]  = '{16'h8001, 2'b10, 4'd1,  16'hC000};
      vecs[4]  = '{16'h8001, 2'b11, 4'd1,  16'h0003};
      vecs[5]  = '{16'h8001, 2'b10, 4'd15, 16'hFFFF};
      vecs[6]  = '{16'h00F0, 2'b01, 4'd4,  16'h000F};
      vecs[7]  = '{16'hABCD, 2'b11, 4'd4,  16'hBCDA};
      vecs[8]  = '{16'hABCD, 2'b11, 4'd0,  16'hABCD};
      vecs[9]  = '{16'h8000, 2'b10, 4'd0,  16'h8000};
      vecs[10] = '{16'h0F0F, 2'b00, 4'd8,  16'h0F00};

      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd       = CMD_CAP;
      data_in   = '0;
      step();
      step();
      reset = 1'b0;

      // Reset state
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_err", 32'(err_reject), 32'd0);
      check_released("rst");
      check("rst_ready_cap", 32'(cmd_ready), 32'd1);
      cmd = mk_ret(2'b00, 4'd0);
      #1;
      check("rst_ready_ret", 32'(cmd_ready), 32'd0);

      // Spec literal for SHL by 3
      check("cmd_19", 32'(mk_ret(2'b00, 4'd3)), 32'h19);

      // Table: capture, return, expect result two edges after acceptance
      for (int i = 0; i < 11; i++) begin
         do_capture(vecs[i].din);
         check($sformatf("v%0d_count1", i), 32'(fifo_count), 32'd1);
         cmd       = mk_ret(vecs[i].mode, vecs[i].amt);
         cmd_valid = 1'b1;
         #1;
         check($sformatf("v%0d_ready", i), 32'(cmd_ready), 32'd1);
         step();
         cmd_valid = 1'b0;
         check($sformatf("v%0d_early", i), 32'(out_valid), 32'd0);
         check($sformatf("v%0d_count0", i), 32'(fifo_count), 32'd0);
         step();
         check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("v%0d_en", i), 32'(data_out_en), 32'd1);
         check($sformatf("v%0d_data", i), 32'(data_out), 32'(vecs[i].exp));
         step();
         check($sformatf("v%0d_pulse", i), 32'(out_valid), 32'd0);
         check($sformatf("v%0d_hold", i), 32'(data_out), 32'(vecs[i].exp));
      end
      check("tbl_err", 32'(err_reject), 32'd0);

      // Fill to full (pointers start mid-array, so they wrap), reject 9th
      for (int i = 0; i < 8; i++) begin
         fill[i] = 16'h1000 + 16'(i) * 16'h0101;
         do_capture(fill[i]);
      end
      check("full_count", 32'(fifo_count), 32'd8);
      check_released("full");
      cmd       = CMD_CAP;
      data_in   = 16'hDEAD;
      cmd_valid = 1'b1;
      #1;
      check("full_ready", 32'(cmd_ready), 32'd0);
      step();
      cmd_valid = 1'b0;
      check("full_err", 32'(err_reject), 32'd1);
      check("full_count_hold", 32'(fifo_count), 32'd8);

      // Drain back-to-back, pass-through, FIFO order
      cmd = mk_ret(2'b00, 4'd0);
      for (int k = 0; k < 9; k++) begin
         cmd_valid = (k < 8);
         step();
         if (k >= 1) begin
            check($sformatf("drain%0d_valid", k-1), 32'(out_valid), 32'd1);
            check($sformatf("drain%0d_data", k-1), 32'(data_out), 32'(fill[k-1]));
         end
      end
      cmd_valid = 1'b0;
      check("drain_count", 32'(fifo_count), 32'd0);
      check("drain_err_sticky", 32'(err_reject), 32'd1);
      do_flush();
      check("flush1_err", 32'(err_reject), 32'd0);
      check_released("flush1");

      // Return on empty FIFO
      do_capture(16'h5A5A);
      cmd = mk_ret(2'b01, 4'd1);
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      step();
      check("pre_empty_data", 32'(data_out), 32'h2D2D);
      cmd       = mk_ret(2'b00, 4'd0);
      cmd_valid = 1'b1;
      #1;
      check("empty_ready", 32'(cmd_ready), 32'd0);
      step();
      cmd_valid = 1'b0;
      check("empty_err", 32'(err_reject), 32'd1);
      check("empty_count", 32'(fifo_count), 32'd0);
      step();
      check("empty_no_valid", 32'(out_valid), 32'd0);
      check("empty_en_kept", 32'(data_out_en), 32'd1);
      do_flush();
      check("flush2_err", 32'(err_reject), 32'd0);
      check_released("flush2");

      // Three back-to-back returns -> three consecutive pulses
      do_capture(16'h0011);
      do_capture(16'h0022);
      do_capture(16'h0033);
      cmd = mk_ret(2'b00, 4'd1);
      for (int k = 0; k < 4; k++) begin
         cmd_valid = (k < 3);
         step();
         if (k >= 1) begin
            check($sformatf("b2b%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("b2b%0d_data", k), 32'(data_out), 32'(16'h0022 * k));
         end
      end
      cmd_valid = 1'b0;
      step();
      check("b2b_end", 32'(out_valid), 32'd0);

      // Flush one cycle after the second return: only the first result appears
      do_capture(16'h0101);
      do_capture(16'h0202);
      do_capture(16'h0303);
      cmd       = mk_ret(2'b00, 4'd0);
      cmd_valid = 1'b1;
      step();
      step();
      check("fl_first_valid", 32'(out_valid), 32'd1);
      check("fl_first_data", 32'(data_out), 32'h0101);
      check("fl_count1", 32'(fifo_count), 32'd1);
      cmd = CMD_FLUSH;
      step();
      cmd_valid = 1'b0;
      check("fl_suppressed", 32'(out_valid), 32'd0);
      check("fl_count0", 32'(fifo_count), 32'd0);
      check_released("fl");
      step();
      check("fl_none_later", 32'(out_valid), 32'd0);

      // Capture vs completion in the same cycle: completion wins, then capture releases
      do_capture(16'h0F00);
      cmd       = mk_ret(2'b01, 4'd8);
      cmd_valid = 1'b1;
      step();
      cmd     = CMD_CAP;
      data_in = 16'h7777;
      step();
      cmd_valid = 1'b0;
      check("cc_valid", 32'(out_valid), 32'd1);
      check("cc_en", 32'(data_out_en), 32'd1);
      check("cc_data", 32'(data_out), 32'h000F);
      check("cc_count", 32'(fifo_count), 32'd1);
      step();
      check("cc_en_hold", 32'(data_out_en), 32'd1);
      do_capture(16'h8888);
      check_released("cap_rel");
      check("cap_rel_count", 32'(fifo_count), 32'd2);
      do_flush();

      // Reset with a return in stage 1
      cmd       = mk_ret(2'b00, 4'd0);
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      check("pre_rst_err", 32'(err_reject), 32'd1);
      do_capture(16'h4321);
      cmd       = mk_ret(2'b00, 4'd0);
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      reset     = 1'b1;
      step();
      reset = 1'b0;
      check("mrst_valid", 32'(out_valid), 32'd0);
      check("mrst_count", 32'(fifo_count), 32'd0);
      check("mrst_err", 32'(err_reject), 32'd0);
      check_released("mrst");
      step();
      check("mrst_valid_later", 32'(out_valid), 32'd0);
      check_released("mrst_later");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
